// File: rtl/dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_pkg
//  Description : Shared types and constants for the debug UART snapshot dumper
//  Revision    : 1.0 - initial release
// ============================================================================
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        TX   = 2'd2
    } dbg_state_e;

    localparam logic [7:0] DBG_HDR    = 8'hA5;
    localparam int         DBG_NBYTES = 8;

    localparam logic [3:0] SEL_PC_B0  = 4'h0;
    localparam logic [3:0] SEL_PC_B1  = 4'h1;
    localparam logic [3:0] SEL_PC_B2  = 4'h2;
    localparam logic [3:0] SEL_PC_B3  = 4'h3;
    localparam logic [3:0] SEL_CNT_B0 = 4'h8;
    localparam logic [3:0] SEL_CNT_B1 = 4'h9;
    localparam logic [3:0] SEL_CNT_B2 = 4'hA;
    localparam logic [3:0] SEL_CNT_B3 = 4'hB;

    // Snapshot byte index -> upstream selector code (PC bytes, then count bytes)
    function automatic logic [3:0] sel_code(input logic [2:0] idx);
        logic [3:0] code;
        case (idx)
            3'd0:    code = SEL_PC_B0;
            3'd1:    code = SEL_PC_B1;
            3'd2:    code = SEL_PC_B2;
            3'd3:    code = SEL_PC_B3;
            3'd4:    code = SEL_CNT_B0;
            3'd5:    code = SEL_CNT_B1;
            3'd6:    code = SEL_CNT_B2;
            default: code = SEL_CNT_B3;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_byte
//  Description : 8N1 UART byte transmitter. A start pulse loads a byte even on
//                the final cycle of the previous stop bit, so bytes can be
//                chained with no idle gap. done is combinational and marks the
//                last cycle of the stop bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       txd,
    output logic       done
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  BIT_LAST  = 4'd9;

    // Frame bits go out from bit 0; idle fill is all ones so the line rests high
    logic [9:0]  shift_q;
    logic [15:0] baud_q;
    logic [3:0]  bit_q;
    logic        active_q;

    assign txd  = shift_q[0];
    assign done = active_q && (baud_q == BAUD_LAST) && (bit_q == BIT_LAST);

    // Baud counter and shift register; async reset forces the line high at once
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shift_q  <= '1;
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            shift_q  <= {1'b1, data, 1'b0};
            baud_q   <= '0;
            bit_q    <= '0;
            active_q <= 1'b1;
        end else if (active_q) begin
            if (baud_q == BAUD_LAST) begin
                baud_q  <= '0;
                shift_q <= {1'b1, shift_q[9:1]};
                if (bit_q == BIT_LAST) begin
                    active_q <= 1'b0;
                end else begin
                    bit_q <= bit_q + 4'd1;
                end
            end else begin
                baud_q <= baud_q + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbg_uart_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : dbg_uart_dumper
//  Description : Walks the upstream PC/instruction-count byte selector, builds
//                an 8-byte snapshot and sends it as a 9-byte UART frame
//                (0xA5 header + PC[0..3] + count[0..3]).
//  Revision    : 1.0 - initial release
// ============================================================================
module dbg_uart_dumper
    import dbg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int AUTO_PERIOD  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       trigger,
    output logic [3:0] selector,
    input  logic [7:0] sgnl,
    output logic       txd,
    output logic       busy
);

    localparam logic [31:0] AUTO_RELOAD = 32'(AUTO_PERIOD);
    localparam logic [3:0]  TX_LAST     = 4'(DBG_NBYTES);
    localparam logic [2:0]  SCAN_LAST   = 3'(DBG_NBYTES - 1);

    dbg_state_e  state_q;
    logic [3:0]  sel_q;
    logic        busy_q;
    logic [2:0]  byte_idx_q;
    logic        phase_q;
    logic [7:0]  snap_q [DBG_NBYTES];
    logic [3:0]  tx_idx_q;
    logic        tx_pend_q;
    logic [31:0] auto_cnt_q;

    logic        uart_start;
    logic        uart_done;
    logic [7:0]  uart_data;
    logic        auto_fire;

    assign selector = sel_q;
    assign busy     = busy_q;

    // Auto-trigger fires on the cycle the down-count would reach zero, which
    // gives exactly AUTO_PERIOD idle cycles between frames.
    assign auto_fire = (AUTO_PERIOD != 0) && (auto_cnt_q == 32'd1);

    // tx_idx_q is the byte on the line; the header goes first, then the byte
    // after the current one is snap_q[tx_idx_q] because of the header offset.
    assign uart_start = (state_q == TX) &&
                        (tx_pend_q || (uart_done && (tx_idx_q != TX_LAST)));
    assign uart_data  = tx_pend_q ? DBG_HDR : snap_q[tx_idx_q[2:0]];

    // Control FSM: accept/auto-fire, scan the selector, then stream the frame
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            sel_q      <= SEL_PC_B0;
            busy_q     <= 1'b0;
            byte_idx_q <= '0;
            phase_q    <= 1'b0;
            tx_idx_q   <= '0;
            tx_pend_q  <= 1'b0;
            auto_cnt_q <= '0;
            for (int i = 0; i < DBG_NBYTES; i++) begin
                snap_q[i] <= 8'h00;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger || auto_fire) begin
                        state_q    <= SCAN;
                        busy_q     <= 1'b1;
                        byte_idx_q <= '0;
                        phase_q    <= 1'b0;
                        sel_q      <= sel_code(3'd0);
                        auto_cnt_q <= AUTO_RELOAD;
                    end else if (AUTO_PERIOD != 0) begin
                        // A zero count only occurs straight out of reset
                        if (auto_cnt_q == 32'd0) begin
                            auto_cnt_q <= AUTO_RELOAD;
                        end else begin
                            auto_cnt_q <= auto_cnt_q - 32'd1;
                        end
                    end
                end

                SCAN: begin
                    // Second cycle of each selector slot: upstream register has settled
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        snap_q[byte_idx_q] <= sgnl;
                        if (byte_idx_q == SCAN_LAST) begin
                            state_q   <= TX;
                            tx_pend_q <= 1'b1;
                            tx_idx_q  <= '0;
                        end else begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            sel_q      <= sel_code(byte_idx_q + 3'd1);
                        end
                    end
                end

                TX: begin
                    if (tx_pend_q) begin
                        tx_pend_q <= 1'b0;
                    end else if (uart_done) begin
                        if (tx_idx_q == TX_LAST) begin
                            state_q    <= IDLE;
                            busy_q     <= 1'b0;
                            sel_q      <= SEL_PC_B0;
                            auto_cnt_q <= AUTO_RELOAD;
                        end else begin
                            tx_idx_q <= tx_idx_q + 4'd1;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    sel_q   <= SEL_PC_B0;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rstn  (rstn),
        .start (uart_start),
        .data  (uart_data),
        .txd   (txd),
        .done  (uart_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_dbg_uart_dumper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbg_uart_dumper
//  Description : Scoreboard bench for dbg_uart_dumper. Instance A runs the
//                trigger-driven frames, instance B the auto-trigger timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbg_uart_dumper;

    localparam int CPB_A  = 4;
    localparam int CPB_B  = 2;
    localparam int AUTO_B = 10;
    localparam int BUSY_A = 1 + 16 + 90 * CPB_A;
    localparam int BUSY_B = 1 + 16 + 90 * CPB_B;

    logic       clk = 1'b0;
    logic       rstn_a = 1'b1, rstn_b = 1'b1;
    logic       trig_a = 1'b0, trig_b = 1'b0;
    logic [3:0] sel_a, sel_b;
    logic [7:0] sgnl_a = 8'h00, sgnl_b = 8'h00;
    logic       txd_a, txd_b, busy_a, busy_b;

    always #5 clk = ~clk;

    dbg_uart_dumper #(.CLKS_PER_BIT(CPB_A), .AUTO_PERIOD(0)) dut_a (
        .clk(clk), .rstn(rstn_a), .trigger(trig_a), .selector(sel_a),
        .sgnl(sgnl_a), .txd(txd_a), .busy(busy_a));

    dbg_uart_dumper #(.CLKS_PER_BIT(CPB_B), .AUTO_PERIOD(AUTO_B)) dut_b (
        .clk(clk), .rstn(rstn_b), .trigger(trig_b), .selector(sel_b),
        .sgnl(sgnl_b), .txd(txd_b), .busy(busy_b));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // ---------------- upstream counter-block model ----------------
    logic [31:0] pc_a = 32'h0, cnt_a = 32'h0;
    logic        lat_mode = 1'b0;
    logic [3:0]  sel_seen_a = 4'h0;
    int          cyc = 0;

    function automatic logic [7:0] byte_of(input logic [3:0] s, input logic [31:0] pc, input logic [31:0] ct);
        case (s)
            4'h0: return pc[7:0];
            4'h1: return pc[15:8];
            4'h2: return pc[23:16];
            4'h3: return pc[31:24];
            4'h8: return ct[7:0];
            4'h9: return ct[15:8];
            4'hA: return ct[23:16];
            4'hB: return ct[31:24];
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle registered sgnl; in lat_mode the half cycle after a selector
    // change carries a wrong value so a first-edge capture is exposed.
    always @(posedge clk or negedge clk) begin
        if (clk) begin
            sgnl_a <= byte_of(sel_a, pc_a, cnt_a);
        end else begin
            if (lat_mode && (sel_a !== sel_seen_a)) sgnl_a <= ~byte_of(sel_a, pc_a, cnt_a);
            sel_seen_a <= sel_a;
        end
    end

    always @(posedge clk) sgnl_b <= byte_of(sel_b, 32'hCAFEF00D, 32'h00000001);

    // ---------------- scoreboard / reference model for A ----------------
    logic [7:0] exp_q [$];
    int free_a = 0;
    int exp_frames_a = 0;
    int falls_a = 0;
    int rx_bytes_a = 0;

    // Drive a one-cycle trigger starting at the current negedge
    task automatic pulse_a();
        trig_a = 1'b1;
        if (cyc >= free_a) begin
            exp_q.push_back(8'hA5);
            for (int i = 0; i < 4; i++) exp_q.push_back(pc_a[8*i +: 8]);
            for (int i = 0; i < 4; i++) exp_q.push_back(cnt_a[8*i +: 8]);
            free_a = cyc + 1 + BUSY_A;
            exp_frames_a++;
        end
        @(negedge clk);
        trig_a = 1'b0;
    endtask

    task automatic wait_frame_a();
        int n = 0;
        while (cyc < free_a && n < 5000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(busy_a === 1'b0 && n < 5000, "frame_done_a", busy_a, 0);
    endtask

    // UART decoder for A: samples bit centres, pops and compares each byte
    initial begin : rx_a
        bit         act;
        int         c;
        logic [7:0] sh, e;
        act = 0; c = 0; sh = 0;
        forever begin
            @(negedge clk);
            if (!rstn_a) begin
                act = 0;
            end else if (!act) begin
                if (txd_a === 1'b0) begin act = 1; c = 0; end
            end else begin
                c++;
                if (c == 9 * CPB_A + CPB_A / 2) begin
                    chk(txd_a === 1'b1, "stop_bit", txd_a, 1);
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_byte", sh, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk(sh === e, "rx_byte", sh, e);
                    end
                    rx_bytes_a++;
                    act = 0;
                end else if (c % CPB_A == CPB_A / 2) begin
                    if (c / CPB_A == 0) chk(txd_a === 1'b0, "start_bit", txd_a, 0);
                    else sh = {txd_a, sh[7:1]};
                end
            end
        end
    end

    // Cycle monitor for A: selector sequence, start latency, busy length
    initial begin : mon_a
        logic [3:0] seq [8];
        bit pb;
        int k, hi;
        seq = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h8, 4'h9, 4'hA, 4'hB};
        pb = 0; k = 0; hi = 0;
        forever begin
            @(negedge clk);
            if (!rstn_a) begin
                pb = 0; k = 0; hi = 0;
            end else begin
                if (busy_a && !pb) k = 0; else k++;
                if (busy_a) hi++;
                if (busy_a && k < 16) chk(sel_a === seq[k/2], "sel_scan", sel_a, seq[k/2]);
                if (busy_a && k == 16) chk(txd_a === 1'b1, "txd_before_start", txd_a, 1);
                if (busy_a && k == 17) chk(txd_a === 1'b0, "start_latency", txd_a, 0);
                if (!busy_a && pb) begin
                    chk(hi == BUSY_A, "busy_len_a", hi, BUSY_A);
                    chk(sel_a === 4'h0, "sel_idle", sel_a, 0);
                    falls_a++;
                    hi = 0;
                end
                pb = busy_a;
            end
        end
    end

    // Monitor for B: idle gap between frames and busy length
    int gaps_b = 0;
    initial begin : mon_b
        bit pb, seen_fall;
        int hi, lo;
        pb = 0; seen_fall = 0; hi = 0; lo = 0;
        forever begin
            @(negedge clk);
            if (!rstn_b) begin
                pb = 0; seen_fall = 0; hi = 0; lo = 0;
            end else begin
                if (busy_b) hi = pb ? hi + 1 : 1;
                else        lo = pb ? 1 : lo + 1;
                if (busy_b && !pb && seen_fall) begin
                    chk(lo == AUTO_B, "auto_gap", lo, AUTO_B);
                    gaps_b++;
                end
                if (!busy_b && pb) begin
                    chk(hi == BUSY_B, "busy_len_b", hi, BUSY_B);
                    seen_fall = 1;
                end
                pb = busy_b;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int bad;
        bit pb, fell;
        int n;
        #1;
        rstn_a = 1'b0;
        rstn_b = 1'b0;
        #1;
        chk(busy_a === 1'b0, "reset_busy", busy_a, 0);
        chk(txd_a === 1'b1, "reset_txd", txd_a, 1);
        chk(sel_a === 4'h0, "reset_sel", sel_a, 0);
        chk(txd_b === 1'b1, "reset_txd_b", txd_b, 1);
        repeat (3) @(negedge clk);
        rstn_a = 1'b1;
        rstn_b = 1'b1;
        @(negedge clk);
        free_a = cyc;

        // Basic dump with the reference values
        pc_a = 32'h12345678; cnt_a = 32'h000000FF;
        pulse_a();
        wait_frame_a();

        // Retriggers during scan and TX must be ignored
        pc_a = $urandom; cnt_a = $urandom;
        pulse_a();
        repeat (4) @(negedge clk);
        pulse_a();
        repeat (100) @(negedge clk);
        pulse_a();
        wait_frame_a();

        // Capture point: sgnl wrong for the first cycle after each selector change
        lat_mode = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pc_a = $urandom; cnt_a = $urandom;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            pulse_a();
            wait_frame_a();
        end
        lat_mode = 1'b0;

        // Reset during header bit 1 (a zero on the line)
        pc_a = $urandom; cnt_a = $urandom;
        pulse_a();
        repeat (26) @(negedge clk);
        chk(txd_a === 1'b0, "txd_mid_header", txd_a, 0);
        #1 rstn_a = 1'b0;
        #1;
        chk(txd_a === 1'b1, "async_reset_txd", txd_a, 1);
        chk(busy_a === 1'b0, "async_reset_busy", busy_a, 0);
        chk(sel_a === 4'h0, "async_reset_sel", sel_a, 0);
        exp_q.delete();
        exp_frames_a--;
        free_a = 0;
        repeat (3) @(negedge clk);
        #2 rstn_a = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        chk(bad == 0, "quiet_after_reset", bad, 0);
        pc_a = $urandom; cnt_a = $urandom;
        pulse_a();
        wait_frame_a();

        // Trigger on the same edge the auto counter expires on B
        n = 0; pb = busy_b; fell = 0;
        while (!fell && n < 1000) begin
            @(negedge clk);
            fell = pb && !busy_b;
            pb = busy_b;
            n++;
        end
        chk(fell, "b_fall_seen", fell, 1);
        repeat (AUTO_B - 1) @(negedge clk);
        trig_b = 1'b1;
        @(negedge clk);
        trig_b = 1'b0;
        chk(busy_b === 1'b1, "b_simul_start", busy_b, 1);
        repeat (2 * (BUSY_B + AUTO_B) + 20) @(negedge clk);

        chk(exp_q.size() == 0, "sb_empty", exp_q.size(), 0);
        chk(falls_a == exp_frames_a, "frame_count_a", falls_a, exp_frames_a);
        chk(rx_bytes_a == 9 * exp_frames_a, "rx_byte_count_a", rx_bytes_a, 9 * exp_frames_a);
        chk(gaps_b >= 5, "b_auto_frames", gaps_b, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
